// File: rtl/cnn_layer_accel_trans_fifo_pkg.sv
// rtl/cnn_layer_accel_trans_fifo_pkg.sv - shared widths and entry layout for the transport egress FIFO
package cnn_layer_accel_trans_fifo_pkg;

  localparam int META_WTH_DEF  = 64;
  localparam int PYLD_WTH_DEF  = 1024;
  localparam int ENTRY_WTH_DEF = META_WTH_DEF + PYLD_WTH_DEF;

  // Payload sits in the low bits, metadata directly above it.
  localparam int PYLD_FIELD_LO = 0;
  localparam int PYLD_FIELD_HI = PYLD_WTH_DEF - 1;
  localparam int META_FIELD_LO = PYLD_WTH_DEF;
  localparam int META_FIELD_HI = ENTRY_WTH_DEF - 1;

  typedef struct packed {
    logic [META_WTH_DEF-1:0] meta;
    logic [PYLD_WTH_DEF-1:0] pyld;
  } trans_eg_entry_t;

endpackage

// File: rtl/cnn_layer_accel_sdp_ram.sv
// rtl/cnn_layer_accel_sdp_ram.sv - simple dual-port RAM, one write port, one registered read port
module cnn_layer_accel_sdp_ram #(
  parameter int WTH   = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [WTH-1:0] wdata,
  input  logic           re,
  input  logic [AW-1:0]  raddr,
  output logic [WTH-1:0] rdata
);

  logic [WTH-1:0] mem [DEPTH];

  // No reset on storage or the read register; the controller masks stale output.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cnn_layer_accel_trans_eg_sync_fifo.sv
// rtl/cnn_layer_accel_trans_eg_sync_fifo.sv - transport egress sync FIFO with FWFT/standard read and sticky errors
module cnn_layer_accel_trans_eg_sync_fifo
  import cnn_layer_accel_trans_fifo_pkg::*;
#(
  parameter int META_WTH     = META_WTH_DEF,
  parameter int PYLD_WTH     = PYLD_WTH_DEF,
  parameter int DEPTH        = 512,
  parameter int AF_THRESH    = 496,
  parameter int FWFT         = 1,
  parameter int RST_BUSY_CYC = 4,
  localparam int WTH         = META_WTH + PYLD_WTH,
  localparam int AW          = $clog2(DEPTH),
  localparam int PW          = AW + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [WTH-1:0] din,
  input  logic           wr_en,
  input  logic           rd_en,
  output logic [WTH-1:0] dout,
  output logic           valid,
  output logic           full,
  output logic           almost_full,
  output logic           empty,
  output logic [PW-1:0]  count,
  output logic           ovf_err,
  output logic           udf_err,
  output logic           rst_busy
);

  localparam int BW = $clog2(RST_BUSY_CYC + 1);
  localparam logic [PW-1:0] PTR_FULL = {1'b1, {AW{1'b0}}};

  logic [PW-1:0]  wptr, rptr, wptr_n, rptr_n, count_n;
  logic [BW-1:0]  busy_cnt, busy_cnt_n;
  logic           wr_acc, rd_acc, busy_n, full_n, af_n, empty_n, valid_n;
  logic           ram_re, ram_we, out_zero;
  logic [AW-1:0]  ram_raddr;
  logic [WTH-1:0] ram_rdata;

  always_comb begin
    wr_acc     = wr_en & ~full & ~rst_busy;
    rd_acc     = rd_en & ~empty & ~rst_busy;
    wptr_n     = wptr + PW'(wr_acc);
    rptr_n     = rptr + PW'(rd_acc);
    count_n    = count + PW'(wr_acc) - PW'(rd_acc);
    busy_cnt_n = (busy_cnt != '0) ? busy_cnt - BW'(1) : busy_cnt;
    busy_n     = (busy_cnt_n != '0);
    // rptr is the logical head. In FWFT the output register holds the head, so the next
    // fetch targets the entry after a pop, and empty follows the output register.
    if (FWFT != 0) begin
      ram_re    = (~valid & (count != '0)) | (rd_acc & (count > PW'(1)));
      ram_raddr = rptr_n[AW-1:0];
      valid_n   = ram_re | (valid & ~rd_acc);
      empty_n   = ~valid_n;
    end else begin
      ram_re    = rd_acc;
      ram_raddr = rptr[AW-1:0];
      valid_n   = rd_acc;
      empty_n   = (count_n == '0);
    end
    full_n = busy_n | ((wptr_n ^ rptr_n) == PTR_FULL);
    af_n   = (count_n >= PW'(AF_THRESH));
    ram_we = wr_acc & ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      valid       <= 1'b0;
      empty       <= 1'b1;
      full        <= 1'b1;
      almost_full <= 1'b0;
      ovf_err     <= 1'b0;
      udf_err     <= 1'b0;
      rst_busy    <= 1'b1;
      busy_cnt    <= BW'(RST_BUSY_CYC);
      out_zero    <= 1'b1;
    end else begin
      wptr        <= wptr_n;
      rptr        <= rptr_n;
      count       <= count_n;
      valid       <= valid_n;
      empty       <= empty_n;
      full        <= full_n;
      almost_full <= af_n;
      rst_busy    <= busy_n;
      busy_cnt    <= busy_cnt_n;
      if (wr_en & full & ~rst_busy) ovf_err <= 1'b1;
      if (rd_en & empty & ~rst_busy) udf_err <= 1'b1;
      if (ram_re) out_zero <= 1'b0;
    end
  end

  // The read register carries no reset, so dout reads zero until the first fetch after reset.
  assign dout = out_zero ? '0 : ram_rdata;

  cnn_layer_accel_sdp_ram #(
    .WTH   (WTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wptr[AW-1:0]),
    .wdata (din),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_cnn_layer_accel_trans_eg_sync_fifo.sv
// tb/tb_cnn_layer_accel_trans_eg_sync_fifo.sv - self-checking bench for the transport egress FIFO
module tb_cnn_layer_accel_trans_eg_sync_fifo;

  localparam int MW = 8;
  localparam int PYW = 24;
  localparam int EW = MW + PYW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // FWFT instance, DEPTH 8
  logic          rst_a, wr_en_a, rd_en_a;
  logic [EW-1:0] din_a, dout_a;
  logic          valid_a, full_a, af_a, empty_a, ovf_a, udf_a, busy_a;
  logic [3:0]    count_a;

  // standard-read instance, DEPTH 16
  logic          rst_b, wr_en_b, rd_en_b;
  logic [EW-1:0] din_b, dout_b;
  logic          valid_b, full_b, af_b, empty_b, ovf_b, udf_b, busy_b;
  logic [4:0]    count_b;

  logic [EW-1:0] q_a[$];
  logic [EW-1:0] q_b[$];

  cnn_layer_accel_trans_eg_sync_fifo #(
    .META_WTH(MW), .PYLD_WTH(PYW), .DEPTH(8), .AF_THRESH(6), .FWFT(1), .RST_BUSY_CYC(4)
  ) u_dut_a (
    .clk(clk), .rst(rst_a), .din(din_a), .wr_en(wr_en_a), .rd_en(rd_en_a),
    .dout(dout_a), .valid(valid_a), .full(full_a), .almost_full(af_a), .empty(empty_a),
    .count(count_a), .ovf_err(ovf_a), .udf_err(udf_a), .rst_busy(busy_a)
  );

  cnn_layer_accel_trans_eg_sync_fifo #(
    .META_WTH(MW), .PYLD_WTH(PYW), .DEPTH(16), .AF_THRESH(12), .FWFT(0), .RST_BUSY_CYC(4)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .din(din_b), .wr_en(wr_en_b), .rd_en(rd_en_b),
    .dout(dout_b), .valid(valid_b), .full(full_b), .almost_full(af_b), .empty(empty_b),
    .count(count_b), .ovf_err(ovf_b), .udf_err(udf_b), .rst_busy(busy_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [EW-1:0] b_word(input int n);
    logic [7:0] m;
    m = 8'(n);
    return {m, ~m, m, m ^ 8'h3c};
  endfunction

  // FWFT: the head on dout is consumed by the edge following a cycle with rd_en & valid
  always @(negedge clk) begin
    if (valid_a && rd_en_a) begin
      if (q_a.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_a: unexpected pop dout=0x%0h", dout_a);
      end else begin
        check("sb_a_dout", dout_a, q_a.pop_front());
      end
    end
  end

  // Standard read: every valid pulse delivers exactly one entry
  always @(negedge clk) begin
    if (valid_b) begin
      if (q_b.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_b: unexpected data dout=0x%0h", dout_b);
      end else begin
        check("sb_b_dout", dout_b, q_b.pop_front());
      end
    end
  end

  typedef struct {
    logic          wr;
    logic          rd;
    logic [EW-1:0] din;
    logic          push;
    logic [3:0]    cnt;
    logic          full;
    logic          af;
    logic          empty;
    logic          ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic reset_a();
    rst_a = 1'b1; wr_en_a = 1'b0; rd_en_a = 1'b0;
    tick();
    rst_a = 1'b0;
    q_a.delete();
    repeat (4) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      vecs[i].wr    = 1'b1;
      vecs[i].rd    = 1'b0;
      vecs[i].din   = {8'(8'h10 + i), 24'(24'h00ab00 + i)};
      vecs[i].push  = 1'b1;
      vecs[i].cnt   = 4'(i + 1);
      vecs[i].full  = (i == 7);
      vecs[i].af    = (i >= 5);
      vecs[i].empty = (i == 0);
      vecs[i].ovf   = 1'b0;
    end
    vecs[8].wr = 1'b1; vecs[8].rd = 1'b1; vecs[8].din = 32'hdeadbeef; vecs[8].push = 1'b0;
    vecs[8].cnt = 4'd7; vecs[8].full = 1'b0; vecs[8].af = 1'b1; vecs[8].empty = 1'b0;
    vecs[8].ovf = 1'b1;

    // reset and busy window
    rst_a = 1'b1; wr_en_a = 1'b0; rd_en_a = 1'b0; din_a = '0;
    rst_b = 1'b1; wr_en_b = 1'b0; rd_en_b = 1'b0; din_b = '0;
    repeat (3) tick();
    check("rst_count", count_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_empty", empty_a, 1);
    check("rst_full", full_a, 1);
    check("rst_af", af_a, 0);
    check("rst_busy", busy_a, 1);
    check("rst_dout", dout_a, 0);
    check("rst_errs", {ovf_a, udf_a}, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    wr_en_a = 1'b1; din_a = 32'h0000dead;
    for (int i = 0; i < 4; i++) begin
      check("busy_high", busy_a, 1);
      check("busy_full", full_a, 1);
      tick();
    end
    wr_en_a = 1'b0;
    check("busy_done", busy_a, 0);
    check("busy_full_drop", full_a, 0);
    check("busy_empty", empty_a, 1);
    check("busy_wr_ignored", count_a, 0);
    check("busy_no_ovf", ovf_a, 0);

    // FWFT back-to-back with rd_en held high
    rd_en_a = 1'b1;
    wr_en_a = 1'b1; din_a = 32'h11; q_a.push_back(32'h11);
    tick();
    din_a = 32'h22; q_a.push_back(32'h22);
    tick();
    check("fwft_head0", {valid_a, dout_a}, {1'b1, 32'h11});
    din_a = 32'h33; q_a.push_back(32'h33);
    tick();
    check("fwft_head1", {valid_a, dout_a}, {1'b1, 32'h22});
    wr_en_a = 1'b0;
    tick();
    check("fwft_head2", {valid_a, dout_a}, {1'b1, 32'h33});
    tick();
    rd_en_a = 1'b0;
    check("fwft_drain_empty", empty_a, 1);
    check("fwft_drain_count", count_a, 0);

    // almost_full / full / overflow table
    for (int i = 0; i < 9; i++) begin
      wr_en_a = vecs[i].wr; rd_en_a = vecs[i].rd; din_a = vecs[i].din;
      if (vecs[i].push) q_a.push_back(vecs[i].din);
      tick();
      check($sformatf("tbl%0d_count", i), count_a, vecs[i].cnt);
      check($sformatf("tbl%0d_full", i), full_a, vecs[i].full);
      check($sformatf("tbl%0d_af", i), af_a, vecs[i].af);
      check($sformatf("tbl%0d_empty", i), empty_a, vecs[i].empty);
      check($sformatf("tbl%0d_ovf", i), ovf_a, vecs[i].ovf);
    end
    wr_en_a = 1'b0; rd_en_a = 1'b1;
    for (int g = 0; g < 20 && !empty_a; g++) tick();
    rd_en_a = 1'b0;
    check("tbl_drain_empty", empty_a, 1);
    check("tbl_drain_count", count_a, 0);
    check("tbl_sb_drained", q_a.size(), 0);
    check("tbl_ovf_sticky", ovf_a, 1);

    // simultaneous read and write into an empty FIFO
    reset_a();
    check("udf_pre", udf_a, 0);
    wr_en_a = 1'b1; rd_en_a = 1'b1; din_a = 32'ha5; q_a.push_back(32'ha5);
    tick();
    wr_en_a = 1'b0; rd_en_a = 1'b0;
    check("udf_set", udf_a, 1);
    check("udf_count", count_a, 1);
    tick();
    check("udf_head", {valid_a, dout_a}, {1'b1, 32'ha5});
    rd_en_a = 1'b1;
    tick();
    rd_en_a = 1'b0;
    check("udf_after_empty", empty_a, 1);
    check("udf_sticky", udf_a, 1);

    // reset mid-stream
    for (int i = 0; i < 5; i++) begin
      wr_en_a = 1'b1; din_a = 32'hc0 + i;
      tick();
    end
    wr_en_a = 1'b0;
    check("mid_count5", count_a, 5);
    rst_a = 1'b1;
    tick();
    q_a.delete();
    check("mid_count", count_a, 0);
    check("mid_empty", empty_a, 1);
    check("mid_valid", valid_a, 0);
    check("mid_errs", {ovf_a, udf_a}, 0);
    rst_a = 1'b0;
    repeat (4) tick();
    check("mid_no_stale", {valid_a, empty_a, dout_a}, {1'b0, 1'b1, 32'h0});
    wr_en_a = 1'b1; din_a = 32'h5a5a; q_a.push_back(32'h5a5a);
    tick();
    wr_en_a = 1'b0;
    tick();
    check("mid_new_head", {valid_a, dout_a}, {1'b1, 32'h5a5a});
    rd_en_a = 1'b1;
    tick();
    rd_en_a = 1'b0;
    check("mid_final_empty", {empty_a, count_a}, {1'b1, 4'd0});
    check("mid_sb_drained", q_a.size(), 0);

    // standard read mode, two full passes so the pointers wrap
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 16; k++) begin
        wr_en_b = 1'b1; din_b = b_word(r * 16 + k); q_b.push_back(din_b);
        tick();
      end
      wr_en_b = 1'b0;
      check($sformatf("std%0d_full", r), {full_b, af_b, count_b}, {1'b1, 1'b1, 5'd16});
      rd_en_b = 1'b1;
      tick();
      rd_en_b = 1'b0;
      check($sformatf("std%0d_pulse", r), valid_b, 1);
      tick();
      check($sformatf("std%0d_pulse_end", r), valid_b, 0);
      check($sformatf("std%0d_hold", r), dout_b, b_word(r * 16));
      rd_en_b = 1'b1;
      for (int k = 1; k < 16; k++) begin
        tick();
        check($sformatf("std%0d_valid%0d", r, k), valid_b, 1);
      end
      rd_en_b = 1'b0;
      tick();
      check($sformatf("std%0d_done", r), {valid_b, empty_b, count_b}, {1'b0, 1'b1, 5'd0});
      check($sformatf("std%0d_sb", r), q_b.size(), 0);
    end
    check("std_no_errs", {ovf_b, udf_b}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
